// File: rtl/bitwise_seq.sv
// Multi-cycle bitwise logic unit: eight ops on WIDTH-bit operands,
// SLICE bits per clock, LSB slice first, with Hack-style zr/ng flags.
module bitwise_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("bitwise_seq: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nx;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] res;
    logic             last;

    // Operands shift right each RUN cycle, so the live slice is always at the bottom.
    assign sa   = a_r[SLICE-1:0];
    assign sb   = b_r[SLICE-1:0];
    assign last = (cnt == CW'(N - 1));

    always_comb begin
        res = '0;
        unique case (op_r)
            3'b000: res = ~sa;
            3'b001: res = sa & sb;
            3'b010: res = sa | sb;
            3'b011: res = sa ^ sb;
            3'b100: res = ~(sa & sb);
            3'b101: res = ~(sa | sb);
            3'b110: res = ~(sa ^ sb);
            3'b111: res = sa;
        endcase
    end

    // New slices enter at the top; after N shifts slice 0 lands at the LSB.
    generate
        if (N == 1) begin : g_one
            assign shadow_nx = res;
        end else begin : g_many
            assign shadow_nx = {res, shadow[WIDTH-1:SLICE]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            zr     <= 1'b0;
            ng     <= 1'b0;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            shadow <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r   <= op;
                        a_r    <= a;
                        b_r    <= b;
                        cnt    <= '0;
                        shadow <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_r    <= a_r >> SLICE;
                    b_r    <= b_r >> SLICE;
                    shadow <= shadow_nx;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        out   <= shadow_nx;
                        zr    <= (shadow_nx == '0);
                        ng    <= shadow_nx[WIDTH-1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_seq.sv
// Bench for bitwise_seq: cycle model for 16/4, directed checks incl. 8/8.
module tb_bitwise_seq;

    localparam int N = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy, done, zr, ng;
    logic [15:0] out;

    logic        start8 = 1'b0;
    logic [2:0]  op8    = 3'd0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8, done8, zr8, ng8;
    logic [7:0]  out8;

    int n_tests = 0;
    int n_fail  = 0;

    bitwise_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .out(out), .zr(zr), .ng(ng)
    );

    bitwise_seq #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .out(out8), .zr(zr8), .ng(ng8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] f(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            3'd0: f = ~x;
            3'd1: f = x & y;
            3'd2: f = x | y;
            3'd3: f = x ^ y;
            3'd4: f = ~(x & y);
            3'd5: f = ~(x | y);
            3'd6: f = ~(x ^ y);
            default: f = x;
        endcase
    endfunction

    // Cycle model: remaining RUN cycles plus the result computed on the whole word.
    int          m_left = 0;
    bit          armed  = 0;
    logic        m_done = 0;
    logic        m_zr   = 0;
    logic        m_ng   = 0;
    logic [15:0] m_out  = '0;
    logic [15:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            armed  = 1;
            m_left = 0;
            m_done = 0;
            m_out  = '0;
            m_zr   = 0;
            m_ng   = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1;
                m_out  = m_pend;
                m_zr   = (m_pend == 16'h0);
                m_ng   = m_pend[15];
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_pend = f(op, a, b);
                m_left = N;
            end
        end
    end

    always @(negedge clk) begin
        if (armed)
            chk("cycle{busy,done,zr,ng,out}",
                {12'h0, busy, done, zr, ng, out},
                {12'h0, m_left > 0, m_done, m_zr, m_ng, m_out});
    end

    // Counts falling edges until done (or done8); -1 when the bound expires.
    task automatic wait_done(input bit sel8, input int maxc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if ((sel8 ? done8 : done) === 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] eo, input bit ez, input bit en);
        int lat;
        @(posedge clk); #2;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(1'b0, 12, lat);
        chk({name, "_lat"}, lat, 5);
        chk({name, "_out"}, {16'h0, out}, {16'h0, eo});
        chk({name, "_flags"}, {zr, ng}, {ez, en});
    endtask

    initial begin
        int lat;
        int cnt;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_state", {busy, done, zr, ng, out}, 20'h0);
        chk("reset_state8", {busy8, done8, zr8, ng8, out8}, 12'h0);
        reset = 1'b0;

        run_op("not", 3'd0, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b1);
        run_op("and_zero", 3'd1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op("or", 3'd2, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
        run_op("nor", 3'd5, 16'h00F0, 16'h0F00, 16'hF00F, 1'b0, 1'b1);
        run_op("xnor", 3'd6, 16'h5A5A, 16'h5A5A, 16'hFFFF, 1'b0, 1'b1);

        // Inputs change and start pulses mid-RUN; latched operands must win.
        @(posedge clk); #2;
        op = 3'd3; a = 16'h1234; b = 16'h0F0F; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(1'b0, 12, lat);
        chk("xor_lat", lat, 3);
        chk("xor_out", {16'h0, out}, 32'h1D3B);
        count_done(8, cnt);
        chk("xor_single_done", cnt, 0);

        // Back-to-back with start held; new operands presented in DONE.
        @(posedge clk); #2;
        op = 3'd4; a = 16'hAAAA; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #2;
        wait_done(1'b0, 12, lat);
        chk("nand_lat", lat, 5);
        chk("nand_out", {16'h0, out}, 32'h5555);
        #1;
        op = 3'd7; a = 16'h8001; b = 16'h0000;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(1'b0, 12, lat);
        chk("b2b_gap", lat, 5);
        chk("pass_out", {16'h0, out}, 32'h8001);
        chk("pass_flags", {zr, ng}, 2'b01);

        // Reset during the second RUN cycle.
        @(posedge clk); #2;
        op = 3'd0; a = 16'h0F0F; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("midrun_reset", {busy, done, zr, ng, out}, 20'h0);
        count_done(8, cnt);
        chk("midrun_no_done", cnt, 0);

        // Single-slice configuration.
        @(posedge clk); #2;
        op8 = 3'd5; a8 = 8'h0F; b8 = 8'h30; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        wait_done(1'b1, 8, lat);
        chk("w8_lat", lat, 2);
        chk("w8_out", {24'h0, out8}, 32'hC0);
        chk("w8_flags", {zr8, ng8}, 2'b01);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise_seq.md
Name: bitwise_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 16-bit inverter.
- Applies one of eight bitwise operations to WIDTH-bit operands, SLICE bits per clock, LSB slice first.
- Uses a start/busy/done handshake and produces Hack-ALU-style zr/ng flags.
- Sits beside the ALU as a narrow-datapath logic unit, and lets the datapath width scale without widening gate arrays.

Parameters:
- WIDTH, 16: operand/result width in bits; must be an exact multiple of SLICE.
- SLICE, 4: bits processed per clock; 1 <= SLICE <= WIDTH.
- Derived N = WIDTH/SLICE: slice count. Counter width is ceil(log2(N)), minimum 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  operation select, latched with start.
- a  in  WIDTH  operand A, latched with start.
- b  in  WIDTH  operand B, latched with start.
- busy  out  1  high while slices are being processed (RUN).
- done  out  1  one-cycle pulse: out/zr/ng just updated.
- out  out  WIDTH  result register; holds until next completion.
- zr  out  1  result == 0, updated with out.
- ng  out  1  result MSB, updated with out.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, out=0, zr=0, ng=0, slice counter=0, operand/shadow registers=0.
- op encoding:
  - 000 NOT a, 001 a AND b, 010 a OR b, 011 a XOR b
  - 100 NAND, 101 NOR, 110 XNOR, 111 pass a
  - b is ignored for 000 and 111.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b and op into internal registers, clears the counter and shadow result, and goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - busy=1.
  - Each cycle computes slice i = latched op applied to bits [i*SLICE+SLICE-1 : i*SLICE] and writes it into the shadow result; i increments.
  - After slice N-1 is written, go to DONE.
  - start is ignored in RUN. Input changes are ignored because operands are latched.
- Entry to DONE: on the edge leaving RUN, out is loaded with the complete shadow result; zr and ng are computed from that full result.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back, next state RUN). Otherwise go to IDLE.
- Latency: start sampled at edge k gives busy high for cycles k+1..k+N and done high in cycle k+N+1. Throughput is one result per N+1 cycles.
- out stability: out, zr and ng change only on the edge entering DONE (or reset). Partial results are never visible on out.
- N=1 (SLICE=WIDTH): a single RUN cycle, then DONE.
- Reset mid-operation: in any state, reset wins over start. The operation in flight is discarded, and out/zr/ng return to 0 on that edge.
- start held high continuously: one operation per N+1 cycles. Each new start is accepted in DONE, using the operand/op values present in that cycle.
- Unknown/illegal parameters: a WIDTH not divisible by SLICE is a elaboration error and must be flagged by a generate-time check.

Test Plan:
- NOT, default parameters: WIDTH=16, SLICE=4, op=000, a=0x00FF, start pulse at edge k -> busy high k+1..k+4; done high at k+5; out=0xFF00, zr=0, ng=1.
- AND to zero: op=001, a=0xFFFF, b=0x0000 -> out=0x0000, zr=1, ng=0. The previous out is held unchanged through the RUN cycles.
- Slice ordering and input isolation: op=011, a=0x1234, b=0x0F0F, then change a and b to 0xFFFF during RUN and pulse start mid-RUN -> out=0x1D3B, with no restart and exactly one done pulse.
- Back-to-back: start held high with NAND of 0xAAAA and 0xFFFF, then op=111, a=0x8001 presented in the DONE cycle -> out=0x5555, then out=0x8001 with ng=1. The done pulses are 5 cycles apart.
- Reset mid-run: assert reset at the second RUN cycle -> next cycle state=IDLE, busy=0, done=0, out=0, zr=0, ng=0, and no done pulse follows.
- Alternate configuration WIDTH=8, SLICE=8: op=101, a=0x0F, b=0x30 -> done at k+2; out=0xC0, ng=1.
